keymgr_key_packer: RTL and testbench

Sideload-key writer. Accepts a 128-bit hardware key as a stream of 32-bit words over a valid/ready handshake and assembles it with indexed part-selects. Presents the key as a hw_key_req_t to a downstream key consumer, which reads 32-bit slices of it. Handles wipe-on-ack and explicit clear so that no partial or stale key is ever visible.

---
 rtl/keymgr_pkg.sv | 21 ++
 rtl/keymgr_key_packer_if.sv | 30 +++
 rtl/keymgr_key_packer.sv | 90 +++++++++
 tb/tb_keymgr_key_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keymgr_pkg.sv
// Shared types and defaults for the sideload key packer.
package keymgr_pkg;

   localparam int KeyWidth  = 128;
   localparam int WordWidth = 32;

   typedef struct packed {
      logic [KeyWidth-1:0] key;
   } hw_key_req_t;

   typedef enum logic {
      StFill = 1'b0,
      StFull = 1'b1
   } packer_state_e;

   // Index width that stays legal (>= 1 bit) even for a single-word key.
   function automatic int idx_width(input int num_words);
      return (num_words > 1) ? $clog2(num_words) : 1;
   endfunction

endpackage

// File: rtl/keymgr_key_packer_if.sv
// Word stream in, assembled key out. The packer sits on the slave side.
interface keymgr_key_packer_if #(
   parameter int KeyWidth  = keymgr_pkg::KeyWidth,
   parameter int WordWidth = keymgr_pkg::WordWidth
);
   import keymgr_pkg::*;

   localparam int NumWords = KeyWidth / WordWidth;
   localparam int IdxW     = idx_width(NumWords);

   logic                 word_valid_i;
   logic                 word_ready_o;
   logic [WordWidth-1:0] word_i;
   logic                 clear_i;
   logic                 key_valid_o;
   hw_key_req_t          key_o;
   logic                 key_ack_i;
   logic [IdxW-1:0]      fill_idx_o;

   modport master (
      output word_valid_i, word_i, clear_i, key_ack_i,
      input  word_ready_o, key_valid_o, key_o, fill_idx_o
   );

   modport slave (
      input  word_valid_i, word_i, clear_i, key_ack_i,
      output word_ready_o, key_valid_o, key_o, fill_idx_o
   );

endinterface

// File: rtl/keymgr_key_packer.sv
// Sideload key writer: packs 32-bit words into a full key, exposes it only
// when complete, and wipes it on consumer ack or explicit clear.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  StFill | accepting words into the slot selected by idx
//  StFull | key complete and visible, waiting for ack (or clear)
module keymgr_key_packer #(
   parameter int KeyWidth  = keymgr_pkg::KeyWidth,
   parameter int WordWidth = keymgr_pkg::WordWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   keymgr_key_packer_if.slave  bus
);
   import keymgr_pkg::*;

   localparam int NumWords = KeyWidth / WordWidth;
   localparam int IdxW     = idx_width(NumWords);

   if ((KeyWidth % WordWidth) != 0) begin : g_chk_mult
      $error("KeyWidth must be a multiple of WordWidth");
   end
   if (KeyWidth != $bits(hw_key_req_t)) begin : g_chk_key
      $error("KeyWidth must match hw_key_req_t");
   end

   packer_state_e        state_q, state_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [KeyWidth-1:0]  key_q, key_d;
   logic                 word_hs;
   logic [NumWords-1:0]  slot_en;

   assign word_hs = bus.word_valid_i & (state_q == StFill);

   // One-hot slot enable for the word being handshaked this cycle.
   always_comb begin
      slot_en = '0;
      for (int i = 0; i < NumWords; i++) begin
         slot_en[i] = word_hs && (idx_q == IdxW'(i));
      end
   end

   // Next state: clear beats ack beats handshake; clear drops any word in flight.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      key_d   = key_q;
      if (bus.clear_i) begin
         state_d = StFill;
         idx_d   = '0;
         key_d   = '0;
      end else if (state_q == StFull) begin
         if (bus.key_ack_i) begin
            state_d = StFill;
            key_d   = '0;
         end
      end else if (word_hs) begin
         for (int i = 0; i < NumWords; i++) begin
            if (slot_en[i]) key_d[i*WordWidth +: WordWidth] = bus.word_i;
         end
         if (idx_q == IdxW'(NumWords - 1)) begin
            idx_d   = '0;
            state_d = StFull;
         end else begin
            idx_d = idx_q + IdxW'(1);
         end
      end
   end

   // State, slot index and key storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StFill;
         idx_q   <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
      end
   end

   // Outputs come only from flops; the key is masked until complete.
   assign bus.word_ready_o = (state_q == StFill);
   assign bus.key_valid_o  = (state_q == StFull);
   assign bus.key_o.key    = (state_q == StFull) ? key_q : '0;
   assign bus.fill_idx_o   = idx_q;

endmodule

// File: tb/tb_keymgr_key_packer.sv
// Bench for keymgr_key_packer: table of key fills plus hand sequences for
// clear, async reset and clear/ack collisions. Expected keys go through a queue.
module tb_keymgr_key_packer;
   import keymgr_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   keymgr_key_packer_if bus ();

   keymgr_key_packer dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      logic [31:0]  w [4];
      int           gap_max;
      logic [127:0] exp;
   } vec_t;

   vec_t         vecs [5];
   logic [127:0] sb_q [$];
   int           total = 0;
   int           bad   = 0;
   logic         kv_prev = 1'b0;

   function automatic void check(input string name, input logic [127:0] got,
                                 input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, exp);
      end
   endfunction

   // Scoreboard: each rising key_valid pops one expected key; key must be zero otherwise.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!bus.key_valid_o) check("key_masked", bus.key_o.key, '0);
         if (bus.key_valid_o && !kv_prev) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected got=%h want=none", bus.key_o.key);
            end else begin
               check("sb_key", bus.key_o.key, sb_q.pop_front());
            end
         end
      end
      kv_prev <= bus.key_valid_o;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap, input int exp_idx);
      bit done = 1'b0;
      bus.word_valid_i = 1'b0;
      repeat (gap) step();
      bus.word_valid_i = 1'b1;
      bus.word_i       = w;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (bus.word_ready_o) begin
            check("fill_idx", 128'(bus.fill_idx_o), 128'(exp_idx));
            done = 1'b1;
         end
         step();
      end
      bus.word_valid_i = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL send_timeout got=no_ready want=ready");
      end
   endtask

   task automatic fill(input vec_t v);
      sb_q.push_back(v.exp);
      for (int k = 0; k < 4; k++) begin
         send_word(v.w[k], (v.gap_max > 0) ? int'($urandom_range(0, v.gap_max)) : 0, k);
      end
      @(negedge clk);
      check("full_valid", 128'(bus.key_valid_o), 128'(1));
      check("full_ready", 128'(bus.word_ready_o), 128'(0));
      check("full_idx", 128'(bus.fill_idx_o), 128'(0));
      step();
   endtask

   task automatic expect_empty(input string name);
      @(negedge clk);
      check({name, "_valid"}, 128'(bus.key_valid_o), 128'(0));
      check({name, "_key"}, bus.key_o.key, '0);
      check({name, "_ready"}, 128'(bus.word_ready_o), 128'(1));
      step();
   endtask

   task automatic ack_pulse();
      bus.key_ack_i = 1'b1;
      step();
      bus.key_ack_i = 1'b0;
      expect_empty("ack");
   endtask

   initial begin
      vec_t vc;
      bus.word_valid_i = 1'b0;
      bus.word_i       = '0;
      bus.clear_i      = 1'b0;
      bus.key_ack_i    = 1'b0;

      vecs[0].w = '{32'h89abcdef, 32'h01234567, 32'h0, 32'h0};
      vecs[0].gap_max = 0;
      vecs[0].exp = 128'h00000000_00000000_01234567_89abcdef;
      vecs[1].w = '{32'h89abcdef, 32'h01234567, 32'h0, 32'h0};
      vecs[1].gap_max = 3;
      vecs[1].exp = 128'h00000000_00000000_01234567_89abcdef;
      vecs[2].w = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      vecs[2].gap_max = 2;
      vecs[2].exp = 128'h44444444_33333333_22222222_11111111;
      vecs[3].w = '{32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5, 32'ha5a5a5a5};
      vecs[3].gap_max = 0;
      vecs[3].exp = {4{32'ha5a5a5a5}};
      vecs[4].w = '{32'hffffffff, 32'h0, 32'hffffffff, 32'h0};
      vecs[4].gap_max = 3;
      vecs[4].exp = 128'h00000000_ffffffff_00000000_ffffffff;

      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 128'(bus.key_valid_o), 128'(0));
      check("rst_key", bus.key_o.key, '0);
      check("rst_idx", 128'(bus.fill_idx_o), 128'(0));
      rst_n = 1'b1;
      expect_empty("post_rst");

      for (int v = 0; v < 5; v++) begin
         fill(vecs[v]);
         if (v == 0) begin
            bus.word_valid_i = 1'b1;
            bus.word_i       = 32'hdeadbeef;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               check("hold_key", bus.key_o.key, vecs[0].exp);
               check("hold_ready", 128'(bus.word_ready_o), 128'(0));
               step();
            end
            bus.word_valid_i = 1'b0;
         end
         ack_pulse();
      end

      // Clear mid-fill drops the word presented alongside it.
      send_word(32'h11111111, 0, 0);
      send_word(32'h22222222, 0, 1);
      bus.clear_i      = 1'b1;
      bus.word_valid_i = 1'b1;
      bus.word_i       = 32'hffffffff;
      @(negedge clk);
      check("clr_ready", 128'(bus.word_ready_o), 128'(1));
      step();
      bus.clear_i      = 1'b0;
      bus.word_valid_i = 1'b0;
      @(negedge clk);
      check("clr_idx", 128'(bus.fill_idx_o), 128'(0));
      step();
      fill(vecs[2]);
      ack_pulse();

      // Async reset mid-fill.
      send_word(32'h12345678, 0, 0);
      send_word(32'h9abcdef0, 0, 1);
      send_word(32'h0badf00d, 0, 2);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 128'(bus.key_valid_o), 128'(0));
      check("arst_key", bus.key_o.key, '0);
      check("arst_idx", 128'(bus.fill_idx_o), 128'(0));
      check("arst_ready", 128'(bus.word_ready_o), 128'(1));
      step();
      rst_n = 1'b1;
      fill(vecs[3]);

      // Clear and ack together while full.
      bus.clear_i   = 1'b1;
      bus.key_ack_i = 1'b1;
      step();
      bus.clear_i   = 1'b0;
      bus.key_ack_i = 1'b0;
      @(negedge clk);
      check("clrack_idx", 128'(bus.fill_idx_o), 128'(0));
      step();
      expect_empty("clrack");

      // Ack during fill must not disturb progress or the stored word.
      vc.w = '{32'hcafef00d, 32'h00000001, 32'h00000002, 32'h00000003};
      vc.gap_max = 0;
      vc.exp = 128'h00000003_00000002_00000001_cafef00d;
      sb_q.push_back(vc.exp);
      send_word(vc.w[0], 0, 0);
      bus.key_ack_i = 1'b1;
      step();
      bus.key_ack_i = 1'b0;
      @(negedge clk);
      check("fill_ack_idx", 128'(bus.fill_idx_o), 128'(1));
      check("fill_ack_valid", 128'(bus.key_valid_o), 128'(0));
      step();
      for (int k = 1; k < 4; k++) send_word(vc.w[k], 0, k);
      @(negedge clk);
      check("fill_ack_full", 128'(bus.key_valid_o), 128'(1));
      step();
      ack_pulse();

      repeat (2) step();
      check("sb_drained", 128'(sb_q.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
